cache_mem_bridge: RTL

Memory-side responder for the cache's block interface. It accepts one block-wide read (refill) or write (write-back) request from the cache datapath and serves it as a sequence of word-wide transactions on the word memory bus. Read beats are reassembled into a block, and a one-cycle `cache_ack` is returned on completion. It sits between the cache and the word-addressed main memory/bus.

---
 rtl/cache_mem_pkg.sv | 20 ++
 rtl/cache_mem_bridge.sv | 112 +++++++++++
 2 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and size helpers for the cache-to-word-bus block bridge.
package cache_mem_pkg;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  typedef enum logic {READ, WRITE} op_t;

  function automatic int calc_beats(input int block_size, input int data_size);
    return block_size / data_size;
  endfunction

  // Never narrower than one bit, so a single-beat block still has a counter.
  function automatic int calc_beat_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int calc_offset(input int block_size, input int byte_size);
    return $clog2(block_size / byte_size);
  endfunction

endpackage

// File: rtl/cache_mem_bridge.sv
// Serves one block read/write from the cache as BLOCK_SIZE/DATA_SIZE word beats.
// Latency: Beats+1 cycles accept-to-ack, plus one cycle per word_ack wait cycle.
// Backpressure: each beat's strobe, address and data hold until word_ack.
module cache_mem_bridge
  import cache_mem_pkg::*;
#(
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cache_rd_en,
  input  logic                           cache_wr_en,
  input  logic [ADDR_SIZE-1:0]           cache_addr,
  input  logic [BLOCK_SIZE-1:0]          cache_wr_data,
  output logic [BLOCK_SIZE-1:0]          cache_rd_data,
  output logic                           cache_ack,
  output logic                           cache_busy,
  output logic                           word_rd_en,
  output logic                           word_wr_en,
  output logic [ADDR_SIZE-1:0]           word_addr,
  output logic [DATA_SIZE-1:0]           word_wr_data,
  output logic [DATA_SIZE/BYTE_SIZE-1:0] word_sel,
  input  logic [DATA_SIZE-1:0]           word_rd_data,
  input  logic                           word_ack
);

  localparam int BEATS      = calc_beats(BLOCK_SIZE, DATA_SIZE);
  localparam int BEAT_BITS  = calc_beat_bits(BEATS);
  localparam int OFFSET     = calc_offset(BLOCK_SIZE, BYTE_SIZE);
  localparam int WORD_BYTES = DATA_SIZE / BYTE_SIZE;

  localparam logic [ADDR_SIZE-1:0] OFF_MASK  = ADDR_SIZE'((64'd1 << OFFSET) - 64'd1);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  state_t                 state_q, state_d;
  op_t                    op_q;
  logic [BEAT_BITS-1:0]   cnt_q;
  logic [ADDR_SIZE-1:0]   base_q;
  logic [DATA_SIZE-1:0]   buf_q [BEATS];

  logic accept_wr, accept_rd, beat_ack, in_beat;

  always_comb begin
    state_d   = state_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    beat_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins a simultaneous request; the dropped read is re-issued upstream.
        if (cache_wr_en) begin
          accept_wr = 1'b1;
          state_d   = BEAT;
        end else if (cache_rd_en) begin
          accept_rd = 1'b1;
          state_d   = BEAT;
        end
      end
      BEAT: begin
        if (word_ack) begin
          beat_ack = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= READ;
      cnt_q   <= '0;
      base_q  <= '0;
      for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept_wr || accept_rd) begin
        base_q <= cache_addr & ~OFF_MASK;
        cnt_q  <= '0;
        op_q   <= accept_wr ? WRITE : READ;
      end
      if (accept_wr) begin
        for (int i = 0; i < BEATS; i++) buf_q[i] <= cache_wr_data[i*DATA_SIZE +: DATA_SIZE];
      end
      if (beat_ack) begin
        if (op_q == READ) buf_q[cnt_q] <= word_rd_data;
        cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + BEAT_BITS'(1);
      end
    end
  end

  assign in_beat      = (state_q == BEAT);
  assign cache_busy   = (state_q != IDLE);
  assign cache_ack    = (state_q == DONE);
  assign word_rd_en   = in_beat && (op_q == READ);
  assign word_wr_en   = in_beat && (op_q == WRITE);
  // Address arithmetic is modulo 2^ADDR_SIZE, so a top-of-memory block wraps.
  assign word_addr    = in_beat ? base_q + ADDR_SIZE'(cnt_q) * ADDR_SIZE'(WORD_BYTES) : '0;
  assign word_wr_data = in_beat ? buf_q[cnt_q] : '0;
  assign word_sel     = in_beat ? '1 : '0;

  always_comb begin
    cache_rd_data = '0;
    for (int i = 0; i < BEATS; i++) cache_rd_data[i*DATA_SIZE +: DATA_SIZE] = buf_q[i];
  end

endmodule
